// File: rtl/i8088_bus_master.sv
// 8088-style minimum-mode bus master: T1..T4 bus cycles with READY wait states.
// Wait states are capped at MaxWait; an over-limit cycle ends with err instead of done.
module i8088_bus_master #(
    parameter int AddressWidth = 20,
    parameter int MaxWait      = 15
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    req,
    input  logic                    req_we,
    input  logic                    req_iom,
    input  logic [AddressWidth-1:0] req_addr,
    input  logic [7:0]              req_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [7:0]              rdata,
    output logic                    ALE,
    output logic                    RD,
    output logic                    WR,
    output logic                    IOM,
    output logic [AddressWidth-1:0] Address,
    inout  wire  [7:0]              Data,
    input  logic                    READY
);

    localparam int CW = $clog2(MaxWait + 1);

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        T3,
        TW,
        T4
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    we_q;
    logic                    iom_q;
    logic                    abort_q;
    logic                    abort_nxt;
    logic [AddressWidth-1:0] addr_q;
    logic [7:0]              wdata_q;
    logic [7:0]              rdata_q;
    logic [CW-1:0]           wcnt_q;
    logic [CW-1:0]           wcnt_nxt;
    logic                    load;
    logic                    cap;
    logic                    strobe;
    logic                    data_oe;

    always_comb begin
        state_nxt = state;
        abort_nxt = abort_q;
        wcnt_nxt  = wcnt_q;
        load      = 1'b0;
        cap       = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    load      = 1'b1;
                    state_nxt = T1;
                end
            end
            T1: state_nxt = T2;
            T2: begin
                state_nxt = T3;
                wcnt_nxt  = '0;
            end
            T3: begin
                if (READY) begin
                    state_nxt = T4;
                    cap       = ~we_q;
                end else begin
                    state_nxt = TW;
                    wcnt_nxt  = CW'(1);
                end
            end
            TW: begin
                if (READY) begin
                    state_nxt = T4;
                    cap       = ~we_q;
                end else if (wcnt_q == CW'(MaxWait)) begin
                    // Responder never answered: finish the cycle without data.
                    state_nxt = T4;
                    abort_nxt = 1'b1;
                end else begin
                    wcnt_nxt = wcnt_q + CW'(1);
                end
            end
            T4: begin
                if (req) begin
                    load      = 1'b1;
                    state_nxt = T1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (load) begin
            abort_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            iom_q   <= 1'b0;
            abort_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wcnt_q  <= '0;
        end else begin
            state   <= state_nxt;
            abort_q <= abort_nxt;
            wcnt_q  <= wcnt_nxt;
            if (load) begin
                we_q    <= req_we;
                iom_q   <= req_iom;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (cap) begin
                rdata_q <= Data;
            end
        end
    end

    assign strobe  = (state == T2) || (state == T3) || (state == TW);
    assign data_oe = we_q && (strobe || (state == T4));

    assign busy    = (state != IDLE);
    assign ALE     = (state == T1);
    assign RD      = ~(strobe && !we_q);
    assign WR      = ~(strobe && we_q);
    assign done    = (state == T4) && !abort_q;
    assign err     = (state == T4) && abort_q;
    assign IOM     = iom_q;
    assign Address = addr_q;
    assign rdata   = rdata_q;
    assign Data    = data_oe ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_i8088_bus_master.sv
// Directed bench for i8088_bus_master with a small bus responder.
// Memory reads return addr^0x4A; writes land in a log that IO reads return.
module tb_i8088_bus_master;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req;
    logic        req_we;
    logic        req_iom;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  rdata;
    logic        ALE;
    logic        RD;
    logic        WR;
    logic        IOM;
    logic [19:0] Address;
    tri1  [7:0]  Data;
    logic        READY;

    int chk  = 0;
    int pass = 0;

    logic [7:0] wmem [512];
    logic [7:0] resp_val;

    i8088_bus_master dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req       (req),
        .req_we    (req_we),
        .req_iom   (req_iom),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .ALE       (ALE),
        .RD        (RD),
        .WR        (WR),
        .IOM       (IOM),
        .Address   (Address),
        .Data      (Data),
        .READY     (READY)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        resp_val = Address[7:0] ^ 8'h4A;
        if (IOM) resp_val = wmem[{1'b1, Address[7:0]}];
    end

    assign Data = (RD == 1'b0) ? resp_val : 8'hzz;

    always @(posedge CLK) begin
        if (WR == 1'b0) wmem[{IOM, Address[7:0]}] <= Data;
    end

    task automatic issue(input logic we, input logic iom,
                         input logic [19:0] addr, input logic [7:0] wd);
        req       = 1'b1;
        req_we    = we;
        req_iom   = iom;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge CLK);
        #1;
        req       = 1'b0;
        req_we    = ~we;
        req_iom   = ~iom;
        req_addr  = 20'hFFFFF;
        req_wdata = ~wd;
    endtask

    task automatic observe(
        input  logic        we,
        input  logic        iom,
        input  logic [19:0] addr,
        input  logic [7:0]  wd,
        input  int          wait_n,
        input  int          limit,
        output int          n_ale,
        output int          n_rd,
        output int          n_wr,
        output int          n_both,
        output int          n_done,
        output int          done_at,
        output int          n_err,
        output int          err_at,
        output int          addr_bad,
        output int          data_bad,
        output int          end_at,
        output logic [7:0]  rd_at_done
    );
        n_ale = 0; n_rd = 0; n_wr = 0; n_both = 0;
        n_done = 0; done_at = 0; n_err = 0; err_at = 0;
        addr_bad = 0; data_bad = 0; end_at = 0;
        rd_at_done = 8'h00;
        for (int i = 1; i <= limit; i++) begin
            READY = (i < 3) || (i >= 3 + wait_n);
            if (!busy) begin
                end_at = i;
                break;
            end
            if (ALE) n_ale++;
            if (!RD) n_rd++;
            if (!WR) n_wr++;
            if (!RD && !WR) n_both++;
            if (done) begin
                n_done++;
                if (done_at == 0) begin
                    done_at = i;
                    rd_at_done = rdata;
                end
            end
            if (err) begin
                n_err++;
                if (err_at == 0) err_at = i;
            end
            if (Address !== addr || IOM !== iom) addr_bad++;
            if (ALE && Data !== 8'hFF) data_bad++;
            if (we && (!WR || done || err) && Data !== wd) data_bad++;
            if (!we && (done || err) && Data !== 8'hFF) data_bad++;
            @(posedge CLK);
            #1;
        end
        READY = 1'b1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk++; if ({ALE, RD, WR, IOM} !== 4'b0110)
            $display("FAIL rst_strobes got=%b want=0110", {ALE, RD, WR, IOM});
        else pass++;
        chk++; if (Address !== 20'h0)
            $display("FAIL rst_addr got=%h want=00000", Address);
        else pass++;
        chk++; if ({busy, done, err} !== 3'b000)
            $display("FAIL rst_flags got=%b want=000", {busy, done, err});
        else pass++;
        chk++; if (rdata !== 8'h00)
            $display("FAIL rst_rdata got=%h want=00", rdata);
        else pass++;
        chk++; if (Data !== 8'hFF)
            $display("FAIL rst_data_z got=%h want=FF(pulled)", Data);
        else pass++;
        RESET = 1'b0;
    endtask

    task automatic test_read_zero_wait();
        int a, r, w, b, nd, da, ne, ea, ab, db, en;
        logic [7:0] rv;
        issue(1'b0, 1'b0, 20'h00010, 8'h00);
        observe(1'b0, 1'b0, 20'h00010, 8'h00, 0, 12,
                a, r, w, b, nd, da, ne, ea, ab, db, en, rv);
        chk++; if (a !== 1) $display("FAIL rd_ale got=%0d want=1", a); else pass++;
        chk++; if (r !== 2) $display("FAIL rd_rdlow got=%0d want=2", r); else pass++;
        chk++; if (w !== 0) $display("FAIL rd_wrlow got=%0d want=0", w); else pass++;
        chk++; if (da !== 4) $display("FAIL rd_done_at got=%0d want=4", da); else pass++;
        chk++; if (rv !== 8'h5A) $display("FAIL rd_rdata got=%h want=5a", rv); else pass++;
        chk++; if (ab !== 0) $display("FAIL rd_addr_stable got=%0d want=0", ab); else pass++;
        chk++; if (db !== 0) $display("FAIL rd_data_z got=%0d want=0", db); else pass++;
        chk++; if (en !== 5) $display("FAIL rd_end_at got=%0d want=5", en); else pass++;
        chk++; if (ne !== 0) $display("FAIL rd_err got=%0d want=0", ne); else pass++;
    endtask

    task automatic test_io_write_read();
        int a, r, w, b, nd, da, ne, ea, ab, db, en;
        logic [7:0] rv;
        issue(1'b1, 1'b1, 20'h00003, 8'hC3);
        observe(1'b1, 1'b1, 20'h00003, 8'hC3, 0, 12,
                a, r, w, b, nd, da, ne, ea, ab, db, en, rv);
        chk++; if (w !== 2) $display("FAIL iow_wrlow got=%0d want=2", w); else pass++;
        chk++; if (r !== 0) $display("FAIL iow_rdlow got=%0d want=0", r); else pass++;
        chk++; if (ab !== 0) $display("FAIL iow_iom_addr got=%0d want=0", ab); else pass++;
        chk++; if (db !== 0) $display("FAIL iow_data got=%0d want=0", db); else pass++;
        chk++; if (da !== 4) $display("FAIL iow_done_at got=%0d want=4", da); else pass++;
        issue(1'b0, 1'b1, 20'h00003, 8'h00);
        observe(1'b0, 1'b1, 20'h00003, 8'h00, 0, 12,
                a, r, w, b, nd, da, ne, ea, ab, db, en, rv);
        chk++; if (rv !== 8'hC3) $display("FAIL ior_rdata got=%h want=c3", rv); else pass++;
        chk++; if (da !== 4) $display("FAIL ior_done_at got=%0d want=4", da); else pass++;
    endtask

    task automatic test_wait_states();
        int a, r, w, b, nd, da, ne, ea, ab, db, en;
        logic [7:0] rv;
        issue(1'b0, 1'b0, 20'h00020, 8'h00);
        observe(1'b0, 1'b0, 20'h00020, 8'h00, 3, 20,
                a, r, w, b, nd, da, ne, ea, ab, db, en, rv);
        chk++; if (r !== 5) $display("FAIL ws_rdlow got=%0d want=5", r); else pass++;
        chk++; if (da !== 7) $display("FAIL ws_done_at got=%0d want=7", da); else pass++;
        chk++; if (rv !== 8'h6A) $display("FAIL ws_rdata got=%h want=6a", rv); else pass++;
        chk++; if (ab !== 0) $display("FAIL ws_addr_stable got=%0d want=0", ab); else pass++;
    endtask

    task automatic test_wait_limit();
        int a, r, w, b, nd, da, ne, ea, ab, db, en;
        logic [7:0] rv;
        issue(1'b0, 1'b0, 20'h00030, 8'h00);
        observe(1'b0, 1'b0, 20'h00030, 8'h00, 1000, 40,
                a, r, w, b, nd, da, ne, ea, ab, db, en, rv);
        chk++; if (ea !== 19) $display("FAIL wl_err_at got=%0d want=19", ea); else pass++;
        chk++; if (ne !== 1) $display("FAIL wl_err_cnt got=%0d want=1", ne); else pass++;
        chk++; if (nd !== 0) $display("FAIL wl_done_cnt got=%0d want=0", nd); else pass++;
        chk++; if (r !== 17) $display("FAIL wl_rdlow got=%0d want=17", r); else pass++;
        chk++; if (en !== 20) $display("FAIL wl_end_at got=%0d want=20", en); else pass++;
        chk++; if (rdata !== 8'h6A) $display("FAIL wl_rdata_kept got=%h want=6a", rdata); else pass++;
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        int d1 = 0;
        int d2 = 0;
        int n_ale = 0;
        int end_at = 0;
        logic [19:0] a5 = '0;
        req       = 1'b1;
        req_we    = 1'b1;
        req_iom   = 1'b0;
        req_addr  = 20'h00040;
        req_wdata = 8'h11;
        @(posedge CLK);
        #1;
        req_addr  = 20'h00041;
        req_wdata = 8'h22;
        for (int i = 1; i <= 12; i++) begin
            if (!busy && end_at == 0) end_at = i;
            if (done) begin
                n_done++;
                if (d1 == 0) d1 = i;
                else if (d2 == 0) d2 = i;
            end
            if (ALE) n_ale++;
            if (i == 5) begin
                a5  = Address;
                req = 1'b0;
            end
            @(posedge CLK);
            #1;
        end
        chk++; if (d1 !== 4) $display("FAIL b2b_done1 got=%0d want=4", d1); else pass++;
        chk++; if (d2 !== 8) $display("FAIL b2b_done2 got=%0d want=8", d2); else pass++;
        chk++; if (n_done !== 2) $display("FAIL b2b_done_cnt got=%0d want=2", n_done); else pass++;
        chk++; if (n_ale !== 2) $display("FAIL b2b_ale got=%0d want=2", n_ale); else pass++;
        chk++; if (end_at !== 9) $display("FAIL b2b_busy_end got=%0d want=9", end_at); else pass++;
        chk++; if (a5 !== 20'h00041) $display("FAIL b2b_addr2 got=%h want=00041", a5); else pass++;
        chk++; if (wmem[9'h040] !== 8'h11)
            $display("FAIL b2b_mem40 got=%h want=11", wmem[9'h040]);
        else pass++;
        chk++; if (wmem[9'h041] !== 8'h22)
            $display("FAIL b2b_mem41 got=%h want=22", wmem[9'h041]);
        else pass++;
    endtask

    task automatic test_reset_mid_cycle();
        int a, r, w, b, nd, da, ne, ea, ab, db, en;
        logic [7:0] rv;
        issue(1'b1, 1'b1, 20'h00050, 8'hEE);
        @(posedge CLK);
        #1;
        chk++; if (WR !== 1'b0) $display("FAIL mr_in_t2 got=%b want=0", WR); else pass++;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        chk++; if ({ALE, RD, WR, IOM} !== 4'b0110)
            $display("FAIL mr_strobes got=%b want=0110", {ALE, RD, WR, IOM});
        else pass++;
        chk++; if (Address !== 20'h0) $display("FAIL mr_addr got=%h want=00000", Address); else pass++;
        chk++; if ({busy, done, err} !== 3'b000)
            $display("FAIL mr_flags got=%b want=000", {busy, done, err});
        else pass++;
        chk++; if (Data !== 8'hFF) $display("FAIL mr_data_z got=%h want=FF(pulled)", Data); else pass++;
        chk++; if (rdata !== 8'h00) $display("FAIL mr_rdata got=%h want=00", rdata); else pass++;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        chk++; if ({busy, done, err} !== 3'b000)
            $display("FAIL mr_after got=%b want=000", {busy, done, err});
        else pass++;
        issue(1'b0, 1'b0, 20'h00060, 8'h00);
        observe(1'b0, 1'b0, 20'h00060, 8'h00, 0, 12,
                a, r, w, b, nd, da, ne, ea, ab, db, en, rv);
        chk++; if (da !== 4) $display("FAIL mr_rd_done_at got=%0d want=4", da); else pass++;
        chk++; if (rv !== 8'h2A) $display("FAIL mr_rd_rdata got=%h want=2a", rv); else pass++;
    endtask

    initial begin
        RESET     = 1'b1;
        req       = 1'b0;
        req_we    = 1'b0;
        req_iom   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        READY     = 1'b1;
        test_reset();
        test_read_zero_wait();
        test_io_write_read();
        test_wait_states();
        test_wait_limit();
        test_back_to_back();
        test_reset_mid_cycle();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
